// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared alu_32.
// Latches the winning operands, runs one op, returns result/flags with requester ID.

module alu_32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [1:0]  op_i,
    output logic [31:0] result_o,
    output logic        negative_o,
    output logic        zero_o,
    output logic        c_out_o,
    output logic        overflow_o
);

    logic [31:0] b_eff;
    logic [32:0] sum;

    // SUB reuses the adder as a + ~b + 1, so c_out means "no borrow"
    always_comb begin
        b_eff      = op_i[0] ? ~b_i : b_i;
        sum        = {1'b0, a_i} + {1'b0, b_eff} + {32'd0, op_i[0]};
        result_o   = '0;
        negative_o = 1'b0;
        c_out_o    = 1'b0;
        overflow_o = 1'b0;
        unique case (op_i)
            2'b00, 2'b01: begin
                result_o   = sum[31:0];
                negative_o = sum[31];
                c_out_o    = sum[32];
                overflow_o = (a_i[31] == b_eff[31]) && (sum[31] != a_i[31]);
            end
            2'b10: result_o = a_i & b_i;
            2'b11: result_o = a_i | b_i;
            default: result_o = '0;
        endcase
        zero_o = (result_o == 32'd0);
    end

endmodule

module alu_arbiter #(
    parameter int WIDTH     = 32,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    input  logic [1:0][WIDTH-1:0] req_a,
    input  logic [1:0][WIDTH-1:0] req_b,
    input  logic [1:0][1:0]       req_opcode,
    output logic [1:0]            req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic [3:0]            rsp_flags,
    output logic                  busy,
    output logic [15:0]           op_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t           state_q;
    logic             prio_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic             id_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic [3:0]       rsp_flags_q;
    logic             busy_q;
    logic [15:0]      op_count_q;

    logic             winner;
    logic             accept;

    logic [31:0]      alu_result;
    logic             alu_neg;
    logic             alu_c;
    logic             alu_v;
    logic             alu_zero_unused;

    // Pick the winner: a lone requester wins outright, a tie goes to prio_q
    always_comb begin
        winner = 1'b0;
        unique case (req_valid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = prio_q;
            default: winner = 1'b0;
        endcase
        accept    = rst_n && (state_q == S_IDLE) && (|req_valid);
        req_ready = accept ? (2'b01 << winner) : 2'b00;
    end

    alu_32 u_alu (
        .a_i        (a_q),
        .b_i        (b_q),
        .op_i       (op_q),
        .result_o   (alu_result),
        .negative_o (alu_neg),
        .zero_o     (alu_zero_unused),
        .c_out_o    (alu_c),
        .overflow_o (alu_v)
    );

    // Sequencer: accept one op, run it through the ALU, hold the response until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            prio_q       <= PRIO_INIT;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            busy_q       <= 1'b0;
            op_count_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_q     <= req_a[winner];
                        b_q     <= req_b[winner];
                        op_q    <= req_opcode[winner];
                        id_q    <= winner;
                        prio_q  <= ~winner;
                        busy_q  <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_result_q <= alu_result;
                    rsp_flags_q  <= {alu_neg, (alu_result == 32'd0), alu_c, alu_v};
                    rsp_id_q     <= id_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        op_count_q  <= op_count_q + 16'd1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = busy_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized ops
// against an arithmetic reference model of the ALU and the round-robin rule.

module tb_alu_arbiter;

    localparam bit PRIO = 1'b0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0][31:0] req_a = '0;
    logic [1:0][31:0] req_b = '0;
    logic [1:0][1:0]  req_opcode = '0;
    logic [1:0]       req_ready;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic             rsp_id;
    logic [31:0]      rsp_result;
    logic [3:0]       rsp_flags;
    logic             busy;
    logic [15:0]      op_count;

    int          vectors = 0;
    int          miscompares = 0;
    bit          m_prio;
    logic [15:0] m_count;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .PRIO_INIT(PRIO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_opcode (req_opcode),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .busy       (busy),
        .op_count   (op_count)
    );

    // Returns {result, negative, zero, carry, overflow} from plain integer arithmetic
    function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        longint      sa, sb, t;
        logic [31:0] r;
        logic        n, c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n = 1'b0; c = 1'b0; v = 1'b0; r = '0;
        case (op)
            2'd0: begin
                r = a + b;
                c = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
                t = sa + sb;
                v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
                n = r[31];
            end
            2'd1: begin
                r = a - b;
                c = (a >= b);
                t = sa - sb;
                v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
                n = r[31];
            end
            2'd2: r = a & b;
            default: r = a | b;
        endcase
        return {r, n, (r == 32'd0), c, v};
    endfunction

    // Runs one op from IDLE through handshake; caller has set req_valid/data
    task automatic apply_op(input bit drop, input int stall);
        bit          w;
        logic [35:0] exp;
        #1;
        w   = (req_valid == 2'b11) ? m_prio : req_valid[1];
        exp = ref_alu(req_a[w], req_b[w], req_opcode[w]);
        rsp_ready = (stall == 0);
        vectors++;
        if (req_ready !== (2'b01 << w) || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL grant: req_ready=%b busy=%b, want req_ready=%b busy=0",
                     req_ready, busy, 2'b01 << w);
        end
        @(posedge clk); #1;
        m_prio = ~w;
        if (drop) req_valid[w] = 1'b0;
        vectors++;
        if ({rsp_valid, busy, req_ready} !== 4'b0100) begin
            miscompares++;
            $display("FAIL exec_state: {valid,busy,ready}=%b want 0100",
                     {rsp_valid, busy, req_ready});
        end
        @(posedge clk); #1;
        vectors++;
        if (rsp_valid !== 1'b1 || {rsp_id, rsp_result, rsp_flags} !== {w, exp}) begin
            miscompares++;
            $display("FAIL response: valid=%b id=%b res=%h flags=%b, want 1 %b %h %b",
                     rsp_valid, rsp_id, rsp_result, rsp_flags, w, exp[35:4], exp[3:0]);
        end
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            vectors++;
            if ({rsp_valid, busy, req_ready, rsp_id, rsp_result, rsp_flags}
                !== {2'b11, 2'b00, w, exp}) begin
                miscompares++;
                $display("FAIL stall_hold: valid=%b busy=%b ready=%b id=%b res=%h flags=%b",
                         rsp_valid, busy, req_ready, rsp_id, rsp_result, rsp_flags);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        m_count++;
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== m_count) begin
            miscompares++;
            $display("FAIL handshake: valid=%b busy=%b op_count=%h, want 0 0 %h",
                     rsp_valid, busy, op_count, m_count);
        end
    endtask

    task automatic set_req(input bit i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op);
        req_a[i]      = a;
        req_b[i]      = b;
        req_opcode[i] = op;
        req_valid[i]  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        set_req(0, 32'd10, 32'd3, 2'd0);
        set_req(1, 32'd10, 32'd3, 2'd1);
        repeat (3) begin
            @(posedge clk); #1;
            vectors++;
            if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, busy, op_count} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: ready=%b valid=%b id=%b res=%h flags=%b busy=%b cnt=%h",
                         req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, busy, op_count);
            end
        end
        rst_n   = 1'b1;
        m_prio  = PRIO;
        m_count = '0;
        apply_op(1'b1, 0);
        apply_op(1'b1, 0);
    endtask

    task automatic test_add_overflow();
        set_req(0, 32'h7FFF_FFFF, 32'h0000_0001, 2'd0);
        apply_op(1'b1, 0);
    endtask

    task automatic test_sub_and();
        set_req(1, 32'd5, 32'd5, 2'd1);
        apply_op(1'b1, 0);
        set_req(1, 32'h0000_00F0, 32'h0000_000F, 2'd2);
        apply_op(1'b1, 0);
    endtask

    task automatic test_alternation();
        logic [15:0] start;
        start = op_count;
        set_req(0, 32'h1234_5678, 32'h1111_1111, 2'd0);
        set_req(1, 32'hFFFF_0000, 32'h00FF_FF00, 2'd3);
        for (int i = 0; i < 4; i++) apply_op(1'b0, 0);
        req_valid = 2'b00;
        vectors++;
        if (op_count - start !== 16'd4) begin
            miscompares++;
            $display("FAIL alternation_count: delta=%0d want 4", op_count - start);
        end
    endtask

    task automatic test_stall();
        set_req(0, 32'h8000_0000, 32'h8000_0000, 2'd0);
        apply_op(1'b1, 5);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] == 1'b0 && $urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 3))
                        0: set_req(i[0], $urandom, $urandom, 2'($urandom_range(0, 3)));
                        1: set_req(i[0], 32'h7FFF_FFFF, $urandom, 2'($urandom_range(0, 1)));
                        2: begin
                            req_a[i] = $urandom;
                            set_req(i[0], req_a[i], req_a[i], 2'($urandom_range(0, 3)));
                        end
                        default: set_req(i[0], 32'd0, $urandom, 2'($urandom_range(0, 3)));
                    endcase
                end
            end
            if (req_valid == 2'b00) set_req($urandom_range(0, 1) == 1, $urandom, $urandom, 2'd1);
            apply_op(1'b1, $urandom_range(0, 3));
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_exec();
        set_req(0, 32'd7, 32'd9, 2'd0);
        #1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_exec: valid=%b busy=%b op_count=%h, want 0 0 0000",
                     rsp_valid, busy, op_count);
        end
        @(posedge clk); #1;
        rst_n   = 1'b1;
        m_prio  = PRIO;
        m_count = '0;
        repeat (3) begin
            @(posedge clk); #1;
            vectors++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_no_rsp: valid=%b busy=%b want 0 0", rsp_valid, busy);
            end
        end
    endtask

    task automatic test_wrap();
        force dut.op_count_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.op_count_q;
        @(posedge clk); #1;
        m_count = 16'hFFFF;
        vectors++;
        if (op_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL preload: op_count=%h want ffff", op_count);
        end
        set_req(1, 32'd1, 32'd2, 2'd1);
        apply_op(1'b1, 0);
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_and();
        test_alternation();
        test_stall();
        test_random();
        test_reset_exec();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
